// File: rtl/ckpt_rf_pkg.sv
// Shared constants, types and live-window helpers for the checkpointed
// register file.
package ckpt_rf_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_NUM_READ   = 2;
    localparam int DEF_NUM_CKPT   = 4;

    localparam int REG_ADDR_W = $clog2(DEF_NUM_REGS);
    localparam int CKPT_ID_W  = $clog2(DEF_NUM_CKPT);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CKPT_ID_W-1:0]  ckpt_id_t;

    // Age of a slot relative to the oldest live slot, modulo the slot count.
    function automatic int unsigned ckpt_offset(input int unsigned id,
                                                input int unsigned head,
                                                input int unsigned num_ckpt);
        return (id + num_ckpt - head) % num_ckpt;
    endfunction

    // A slot is restorable only while it lies between head and tail.
    function automatic logic in_live_window(input int unsigned id,
                                            input int unsigned head,
                                            input int unsigned count,
                                            input int unsigned num_ckpt);
        return (count != 0) && (ckpt_offset(id, head, num_ckpt) < count);
    endfunction

endpackage

// File: rtl/ckpt_reg_file_if.sv
// Bus bundle for the checkpointed register file: read ports, write-back port,
// checkpoint commands and status.
interface ckpt_reg_file_if
    import ckpt_rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int NUM_CKPT   = DEF_NUM_CKPT
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int IW = $clog2(NUM_CKPT);

    logic [NUM_READ-1:0]                 rd_en;
    logic [NUM_READ-1:0][AW-1:0]         rd_addr;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_data;

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic          ckpt_take;
    logic [IW-1:0] ckpt_take_id;
    logic          ckpt_release;
    logic          ckpt_restore;
    logic [IW-1:0] ckpt_restore_id;

    logic ckpt_full;
    logic ckpt_empty;
    logic restore_done;
    logic restore_err;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output ckpt_take, ckpt_release, ckpt_restore, ckpt_restore_id,
        input  rd_data, ckpt_take_id, ckpt_full, ckpt_empty,
        input  restore_done, restore_err
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  ckpt_take, ckpt_release, ckpt_restore, ckpt_restore_id,
        output rd_data, ckpt_take_id, ckpt_full, ckpt_empty,
        output restore_done, restore_err
    );

endinterface

// File: rtl/ckpt_slot_ctrl.sv
// Checkpoint slot bookkeeping: circular FIFO pointers, occupancy, restore
// legality and the one-cycle done/error pulses. Holds no register data.
module ckpt_slot_ctrl
    import ckpt_rf_pkg::*;
#(
    parameter int NUM_CKPT = DEF_NUM_CKPT
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        take_req,
    input  logic                        rel_req,
    input  logic                        restore_req,
    input  logic [$clog2(NUM_CKPT)-1:0] restore_id,
    output logic [$clog2(NUM_CKPT)-1:0] tail,
    output logic                        full,
    output logic                        empty,
    output logic                        take_fire,
    output logic                        restore_ok,
    output logic                        restore_done,
    output logic                        restore_err
);
    localparam int IW = $clog2(NUM_CKPT);
    localparam int CW = IW + 1;

    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rel_fire;

    assign full         = (count_q == CW'(NUM_CKPT));
    assign empty        = (count_q == '0);
    assign tail         = tail_q;
    assign restore_done = done_q;
    assign restore_err  = err_q;

    // Decide which commands fire this cycle and compute the next pointers;
    // a legal restore wins over take/release and rewinds the tail.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        restore_ok = restore_req &&
                     in_live_window(32'(restore_id), 32'(head_q), 32'(count_q), NUM_CKPT);
        take_fire  = take_req && !full && !restore_ok;
        rel_fire   = rel_req && !empty && !restore_ok;

        if (restore_ok) begin
            tail_d  = restore_id;
            count_d = CW'(ckpt_offset(32'(restore_id), 32'(head_q), NUM_CKPT));
            done_d  = 1'b1;
        end else begin
            err_d = restore_req;
            if (take_fire) begin
                tail_d = tail_q + 1'b1;
            end
            if (rel_fire) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(take_fire) - CW'(rel_fire);
        end
    end

    // Pointer, occupancy and pulse registers; reset also swallows any pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/ckpt_reg_file.sv
// Register file with asynchronous read ports, write-to-read bypass and
// whole-file checkpoint / rollback. Owns register and snapshot storage;
// slot bookkeeping lives in ckpt_slot_ctrl.
module ckpt_reg_file
    import ckpt_rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int NUM_CKPT   = DEF_NUM_CKPT
)(
    input  logic           clk,
    input  logic           rst,
    ckpt_reg_file_if.slave bus
);
    localparam int IW = $clog2(NUM_CKPT);

    typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf_t;

    rf_t                       regs_q, regs_d;
    rf_t                       regs_wr;
    logic [NUM_CKPT-1:0][NUM_REGS-1:0][DATA_WIDTH-1:0] slots_q, slots_d;

    logic [IW-1:0] tail;
    logic          take_fire;
    logic          restore_ok;

    ckpt_slot_ctrl #(
        .NUM_CKPT (NUM_CKPT)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .take_req     (bus.ckpt_take),
        .rel_req      (bus.ckpt_release),
        .restore_req  (bus.ckpt_restore),
        .restore_id   (bus.ckpt_restore_id),
        .tail         (tail),
        .full         (bus.ckpt_full),
        .empty        (bus.ckpt_empty),
        .take_fire    (take_fire),
        .restore_ok   (restore_ok),
        .restore_done (bus.restore_done),
        .restore_err  (bus.restore_err)
    );

    assign bus.ckpt_take_id = tail;

    // Read ports: r0 and disabled ports read zero; a same-cycle write wins.
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
        logic hit;
        logic byp;
        assign hit = bus.rd_en[gi] && (bus.rd_addr[gi] != '0);
        assign byp = bus.wr_en && (bus.wr_addr == bus.rd_addr[gi]);
        assign bus.rd_data[gi] = !hit ? '0 :
                                 byp  ? bus.wr_data :
                                        regs_q[bus.rd_addr[gi]];
    end

    // Post-write view of the file (what a take snapshots), then rollback override.
    always_comb begin
        regs_wr = regs_q;
        if (bus.wr_en && (bus.wr_addr != '0)) begin
            regs_wr[bus.wr_addr] = bus.wr_data;
        end
        regs_d = restore_ok ? slots_q[bus.ckpt_restore_id] : regs_wr;
    end

    // Snapshot the post-write file into the tail slot on an accepted take.
    always_comb begin
        slots_d = slots_q;
        if (take_fire) begin
            slots_d[tail] = regs_wr;
        end
    end

    // Architectural registers clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Snapshot storage is not reset: a slot is unreachable until written.
    always_ff @(posedge clk) begin
        slots_q <= slots_d;
    end

endmodule

// File: tb/tb_ckpt_reg_file.sv
// Bench for ckpt_reg_file: directed scenarios with literal expectations plus
// a randomized run compared every cycle against an array-based model.
module tb_ckpt_reg_file;
    import ckpt_rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ckpt_reg_file_if bus ();

    ckpt_reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_slot [4][32];
    int          m_head, m_tail, m_count;
    bit          m_done, m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_legal(input int rid);
        return (m_count > 0) && (((rid + 4 - m_head) % 4) < m_count);
    endfunction

    // Model advance on each rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        bit legal, took, rel;
        int rid;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
            m_head = 0; m_tail = 0; m_count = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            rid    = int'(bus.ckpt_restore_id);
            legal  = bus.ckpt_restore && m_legal(rid);
            if (legal) begin
                for (int r = 0; r < 32; r++) m_regs[r] = m_slot[rid][r];
                m_count = (rid + 4 - m_head) % 4;
                m_tail  = rid;
                m_done  = 1;
            end else begin
                m_err = bus.ckpt_restore;
                if (bus.wr_en && bus.wr_addr != 0) m_regs[bus.wr_addr] = bus.wr_data;
                took = bus.ckpt_take && (m_count < 4);
                rel  = bus.ckpt_release && (m_count > 0);
                if (took) begin
                    for (int r = 0; r < 32; r++) m_slot[m_tail][r] = m_regs[r];
                    m_tail = (m_tail + 1) % 4;
                end
                if (rel) m_head = (m_head + 1) % 4;
                m_count = m_count + int'(took) - int'(rel);
            end
        end
    end

    function automatic logic [31:0] m_read(input logic en, input logic [4:0] a);
        if (!en || a == 0) return 32'h0;
        if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return m_regs[a];
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rd0", {32'h0, bus.rd_data[0]}, {32'h0, m_read(bus.rd_en[0], bus.rd_addr[0])});
            check("rd1", {32'h0, bus.rd_data[1]}, {32'h0, m_read(bus.rd_en[1], bus.rd_addr[1])});
            check("take_id", 64'(bus.ckpt_take_id), 64'(m_tail));
            check("full", 64'(bus.ckpt_full), 64'(m_count == 4));
            check("empty", 64'(bus.ckpt_empty), 64'(m_count == 0));
            check("done", 64'(bus.restore_done), 64'(m_done));
            check("err", 64'(bus.restore_err), 64'(m_err));
        end
    end

    task automatic idle();
        bus.rd_en = '0; bus.rd_addr[0] = '0; bus.rd_addr[1] = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.ckpt_take = 1'b0; bus.ckpt_release = 1'b0;
        bus.ckpt_restore = 1'b0; bus.ckpt_restore_id = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    endtask

    task automatic rd0(input logic [4:0] a);
        bus.rd_en[0] = 1'b1; bus.rd_addr[0] = a;
    endtask

    task automatic rd1(input logic [4:0] a);
        bus.rd_en[1] = 1'b1; bus.rd_addr[1] = a;
    endtask

    task automatic restore(input ckpt_id_t id);
        bus.ckpt_restore = 1'b1; bus.ckpt_restore_id = id;
    endtask

    initial begin
        idle();
        do_reset();
        chk_en = 1'b1;

        // Reset state
        rd0(5'd5);
        @(negedge clk);
        check("rst_empty", 64'(bus.ckpt_empty), 64'd1);
        check("rst_full", 64'(bus.ckpt_full), 64'd0);
        check("rst_take_id", 64'(bus.ckpt_take_id), 64'd0);
        check("rst_done_err", 64'({bus.restore_done, bus.restore_err}), 64'd0);
        check("rst_r5", 64'(bus.rd_data[0]), 64'd0);
        tick();

        // Bypass and r0
        wr(5'd5, 32'hDEADBEEF); rd0(5'd5);
        @(negedge clk);
        check("bypass_r5", 64'(bus.rd_data[0]), 64'hDEADBEEF);
        tick();
        wr(5'd0, 32'h1); rd1(5'd0);
        @(negedge clk);
        check("r0_wr_cycle", 64'(bus.rd_data[1]), 64'd0);
        tick();
        rd0(5'd5); rd1(5'd0);
        @(negedge clk);
        check("r5_stored", 64'(bus.rd_data[0]), 64'hDEADBEEF);
        check("r0_after", 64'(bus.rd_data[1]), 64'd0);
        tick();

        // Full: four takes fill, fifth is ignored
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            wr(5'd1, 32'(k)); bus.ckpt_take = 1'b1;
            tick();
        end
        wr(5'd1, 32'd100); bus.ckpt_take = 1'b1;
        tick();
        rd0(5'd1);
        @(negedge clk);
        check("full_flag", 64'(bus.ckpt_full), 64'd1);
        check("full_take_id", 64'(bus.ckpt_take_id), 64'd0);
        check("full_r1", 64'(bus.rd_data[0]), 64'd100);
        restore(2'd3);
        tick();
        rd0(5'd1);
        @(negedge clk);
        check("full_slot3_r1", 64'(bus.rd_data[0]), 64'd4);
        check("full_rst_done", 64'(bus.restore_done), 64'd1);
        check("full_rst_tail", 64'(bus.ckpt_take_id), 64'd3);
        tick();

        // Restore to oldest
        do_reset();
        wr(5'd3, 32'd7); tick();
        bus.ckpt_take = 1'b1; tick();
        wr(5'd3, 32'd9); tick();
        bus.ckpt_take = 1'b1; tick();
        wr(5'd3, 32'd11); tick();
        restore(2'd0); tick();
        rd0(5'd3);
        @(negedge clk);
        check("rest_r3", 64'(bus.rd_data[0]), 64'd7);
        check("rest_done", 64'(bus.restore_done), 64'd1);
        check("rest_empty", 64'(bus.ckpt_empty), 64'd1);
        check("rest_tail", 64'(bus.ckpt_take_id), 64'd0);
        tick();
        @(negedge clk);
        check("rest_done_once", 64'(bus.restore_done), 64'd0);
        tick();

        // Wrap-around
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr(5'd2, 32'(10 + k)); bus.ckpt_take = 1'b1; tick();
        end
        for (int k = 0; k < 3; k++) begin
            bus.ckpt_release = 1'b1; tick();
        end
        @(negedge clk);
        check("wrap_id3", 64'(bus.ckpt_take_id), 64'd3);
        wr(5'd2, 32'd20); bus.ckpt_take = 1'b1; tick();
        @(negedge clk);
        check("wrap_id0", 64'(bus.ckpt_take_id), 64'd0);
        wr(5'd2, 32'd21); bus.ckpt_take = 1'b1; tick();
        wr(5'd2, 32'd30); tick();
        restore(2'd0); tick();
        rd0(5'd2);
        @(negedge clk);
        check("wrap_r2", 64'(bus.rd_data[0]), 64'd21);
        check("wrap_done", 64'(bus.restore_done), 64'd1);
        check("wrap_tail", 64'(bus.ckpt_take_id), 64'd0);
        check("wrap_not_empty", 64'(bus.ckpt_empty), 64'd0);
        bus.ckpt_release = 1'b1; tick();
        @(negedge clk);
        check("wrap_count1", 64'(bus.ckpt_empty), 64'd1);
        tick();

        // Illegal restore: head=1, count=1, id 2 outside window
        do_reset();
        wr(5'd6, 32'h66); bus.ckpt_take = 1'b1; tick();
        bus.ckpt_take = 1'b1; tick();
        bus.ckpt_release = 1'b1; tick();
        restore(2'd2); tick();
        rd0(5'd6);
        @(negedge clk);
        check("ill_err", 64'(bus.restore_err), 64'd1);
        check("ill_done", 64'(bus.restore_done), 64'd0);
        check("ill_tail", 64'(bus.ckpt_take_id), 64'd2);
        check("ill_r6", 64'(bus.rd_data[0]), 64'h66);
        tick();
        @(negedge clk);
        check("ill_err_once", 64'(bus.restore_err), 64'd0);
        // Reset in the request cycle suppresses the pulse
        restore(2'd2); rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check("rst_supp_err", 64'(bus.restore_err), 64'd0);
        check("rst_supp_empty", 64'(bus.ckpt_empty), 64'd1);
        tick();

        // Collision: restore + write + take in one cycle
        do_reset();
        wr(5'd4, 32'd3); tick();
        bus.ckpt_take = 1'b1; tick();
        restore(2'd0); wr(5'd4, 32'd5); bus.ckpt_take = 1'b1; tick();
        rd0(5'd4);
        @(negedge clk);
        check("coll_r4", 64'(bus.rd_data[0]), 64'd3);
        check("coll_empty", 64'(bus.ckpt_empty), 64'd1);
        check("coll_tail", 64'(bus.ckpt_take_id), 64'd0);
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int rid;
            rst = ($urandom_range(0, 149) == 0);
            bus.wr_en   = $urandom_range(0, 1) == 1;
            bus.wr_addr = 5'($urandom_range(0, 7));
            bus.wr_data = $urandom;
            bus.rd_en   = 2'($urandom_range(0, 3));
            bus.rd_addr[0] = 5'($urandom_range(0, 7));
            bus.rd_addr[1] = 5'($urandom_range(0, 7));
            bus.ckpt_take    = $urandom_range(0, 9) < 3;
            bus.ckpt_release = $urandom_range(0, 9) < 2;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) rid = (m_head + $urandom_range(0, 3)) % 4;
                else rid = $urandom_range(0, 3);
                bus.ckpt_restore    = 1'b1;
                bus.ckpt_restore_id = 2'(rid);
                if (!m_legal(rid)) begin
                    bus.wr_en = 1'b0; bus.ckpt_take = 1'b0; bus.ckpt_release = 1'b0;
                end
            end
            @(negedge clk);
            @(posedge clk);
            #1;
            idle();
            rst = 1'b0;
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
